// File: rtl/conv_pingpong_ctrl.sv
// Ping-pong controller for two conv2 feature-map banks: a producer fills one bank while a consumer drains the other.
// Optional statistics counters (frames_wr/frames_rd/stall_cyc) are enabled with `define CONV_PINGPONG_STATS_EN.
module conv_pingpong_ctrl #(
    parameter int AW     = 12,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prod_start_i,
    output logic          prod_grant_o,
    output logic          prod_bank_o,
    input  logic          prod_we_i,
    input  logic [AW-1:0] prod_addr_i,
    input  logic [DW-1:0] prod_din_i,
    input  logic          prod_done_i,
    input  logic          cons_start_i,
    output logic          cons_grant_o,
    output logic          cons_bank_o,
    input  logic          cons_re_i,
    input  logic [AW-1:0] cons_addr_i,
    input  logic          cons_done_i,
    output logic [DW-1:0] cons_dout_o,
    output logic          cons_dvalid_o,
    output logic          err_o,
`ifdef CONV_PINGPONG_STATS_EN
    output logic [15:0]   frames_wr_o,
    output logic [15:0]   frames_rd_o,
    output logic [31:0]   stall_cyc_o,
`endif
    output logic          bank0_we_o,
    output logic [AW-1:0] bank0_addr_o,
    output logic [DW-1:0] bank0_din_o,
    input  logic [DW-1:0] bank0_dout_i,
    output logic          bank1_we_o,
    output logic [AW-1:0] bank1_addr_o,
    output logic [DW-1:0] bank1_din_o,
    input  logic [DW-1:0] bank1_dout_i
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WRITING = 2'd1,
        ST_FULL    = 2'd2,
        ST_READING = 2'd3
    } bank_st_e;

    bank_st_e st_q [2];
    bank_st_e st_d [2];
    logic wp_q, wp_d, rp_q, rp_d;
    logic pg_q, pg_d, cg_q, cg_d;
    logic err_q, err_d;
    logic prod_done_ok, cons_done_ok, prod_bank_free;

    logic [RD_LAT-1:0] vld_q, sel_q;
    logic [RD_LAT:0]   vld_sh, sel_sh;
    logic              rd_issue;

    assign prod_done_ok = prod_done_i & pg_q;
    assign cons_done_ok = cons_done_i & cg_q;
    // A bank freed by cons_done this cycle can be granted to a waiting producer on the same edge.
    assign prod_bank_free = (st_q[wp_q] == ST_FREE) || (cons_done_ok && (rp_q == wp_q));

    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        wp_d    = wp_q;
        rp_d    = rp_q;
        pg_d    = pg_q;
        cg_d    = cg_q;
        err_d   = err_q;

        if (cons_done_ok) begin
            st_d[rp_q] = ST_FREE;
            rp_d       = ~rp_q;
            cg_d       = 1'b0;
        end else if (!cg_q && cons_start_i && (st_q[rp_q] == ST_FULL)) begin
            st_d[rp_q] = ST_READING;
            cg_d       = 1'b1;
        end

        // Producer updates last so a same-edge free-then-grant of one bank ends in WRITING.
        if (prod_done_ok) begin
            st_d[wp_q] = ST_FULL;
            wp_d       = ~wp_q;
            pg_d       = 1'b0;
        end else if (!pg_q && prod_start_i && prod_bank_free) begin
            st_d[wp_q] = ST_WRITING;
            pg_d       = 1'b1;
        end

        if (((prod_we_i | prod_done_i) & ~pg_q) | ((cons_re_i | cons_done_i) & ~cg_q))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0] <= ST_FREE;
            st_q[1] <= ST_FREE;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            pg_q    <= 1'b0;
            cg_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            pg_q    <= pg_d;
            cg_q    <= cg_d;
            err_q   <= err_d;
        end
    end

    assign prod_grant_o = pg_q;
    assign prod_bank_o  = wp_q;
    assign cons_grant_o = cg_q;
    assign cons_bank_o  = rp_q;
    assign err_o        = err_q;

    logic          we_m   [2];
    logic [AW-1:0] addr_m [2];
    logic [DW-1:0] din_m  [2];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we_m[b]   = 1'b0;
            addr_m[b] = '0;
            din_m[b]  = '0;
        end
        if (cg_q)
            addr_m[rp_q] = cons_addr_i;
        if (pg_q) begin
            we_m[wp_q]   = prod_we_i;
            addr_m[wp_q] = prod_addr_i;
            din_m[wp_q]  = prod_din_i;
        end
    end

    assign bank0_we_o   = we_m[0];
    assign bank0_addr_o = addr_m[0];
    assign bank0_din_o  = din_m[0];
    assign bank1_we_o   = we_m[1];
    assign bank1_addr_o = addr_m[1];
    assign bank1_din_o  = din_m[1];

    // Read valid and bank select travel together; the top bit of each shift vector is the output stage.
    assign rd_issue = cons_re_i & cg_q;
    assign vld_sh   = {vld_q, rd_issue};
    assign sel_sh   = {sel_q, rp_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sel_q <= '0;
        end else begin
            vld_q <= vld_sh[RD_LAT-1:0];
            sel_q <= sel_sh[RD_LAT-1:0];
        end
    end

    assign cons_dvalid_o = vld_sh[RD_LAT];
    assign cons_dout_o   = !vld_sh[RD_LAT] ? '0 : (sel_sh[RD_LAT] ? bank1_dout_i : bank0_dout_i);

`ifdef CONV_PINGPONG_STATS_EN
    logic [15:0] frames_wr_q, frames_rd_q;
    logic [31:0] stall_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_wr_q <= '0;
            frames_rd_q <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (prod_done_ok)
                frames_wr_q <= frames_wr_q + 16'd1;
            if (cons_done_ok)
                frames_rd_q <= frames_rd_q + 16'd1;
            if (prod_start_i && !pg_q)
                stall_cyc_q <= stall_cyc_q + 32'd1;
        end
    end

    assign frames_wr_o = frames_wr_q;
    assign frames_rd_o = frames_rd_q;
    assign stall_cyc_o = stall_cyc_q;
`endif

endmodule

// File: tb/tb_conv_pingpong_ctrl.sv
// Directed bench for conv_pingpong_ctrl with a behavioural 1-cycle-latency model of both banks.
module tb_conv_pingpong_ctrl;
    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prod_start = 0, prod_we = 0, prod_done = 0;
    logic [AW-1:0] prod_addr = '0;
    logic [DW-1:0] prod_din = '0;
    logic          cons_start = 0, cons_re = 0, cons_done = 0;
    logic [AW-1:0] cons_addr = '0;
    logic          prod_grant, prod_bank, cons_grant, cons_bank, cons_dvalid, err;
    logic [DW-1:0] cons_dout;
    logic          b0_we, b1_we;
    logic [AW-1:0] b0_addr, b1_addr;
    logic [DW-1:0] b0_din, b1_din;
    logic [DW-1:0] b0_dout = '0, b1_dout = '0;
`ifdef CONV_PINGPONG_STATS_EN
    logic [15:0] frames_wr, frames_rd;
    logic [31:0] stall_cyc;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv_pingpong_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .prod_start_i(prod_start), .prod_grant_o(prod_grant), .prod_bank_o(prod_bank),
        .prod_we_i(prod_we), .prod_addr_i(prod_addr), .prod_din_i(prod_din), .prod_done_i(prod_done),
        .cons_start_i(cons_start), .cons_grant_o(cons_grant), .cons_bank_o(cons_bank),
        .cons_re_i(cons_re), .cons_addr_i(cons_addr), .cons_done_i(cons_done),
        .cons_dout_o(cons_dout), .cons_dvalid_o(cons_dvalid), .err_o(err),
`ifdef CONV_PINGPONG_STATS_EN
        .frames_wr_o(frames_wr), .frames_rd_o(frames_rd), .stall_cyc_o(stall_cyc),
`endif
        .bank0_we_o(b0_we), .bank0_addr_o(b0_addr), .bank0_din_o(b0_din), .bank0_dout_i(b0_dout),
        .bank1_we_o(b1_we), .bank1_addr_o(b1_addr), .bank1_din_o(b1_din), .bank1_dout_i(b1_dout)
    );

    logic [DW-1:0] mem0 [0:4095];
    logic [DW-1:0] mem1 [0:4095];
    always @(posedge clk) begin
        if (b0_we) mem0[b0_addr] <= b0_din;
        if (b1_we) mem1[b1_addr] <= b1_din;
        b0_dout <= mem0[b0_addr];
        b1_dout <= mem1[b1_addr];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (prod_grant !== 1'b0) begin n_fail++; $display("FAIL reset_prod_grant got %0b exp 0", prod_grant); end
        n_checks++; if (cons_grant !== 1'b0) begin n_fail++; $display("FAIL reset_cons_grant got %0b exp 0", cons_grant); end
        n_checks++; if ({prod_bank, cons_bank} !== 2'b00) begin n_fail++; $display("FAIL reset_banks got %b exp 00", {prod_bank, cons_bank}); end
        n_checks++; if ({cons_dvalid, err, b0_we, b1_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {cons_dvalid, err, b0_we, b1_we}); end
        n_checks++; if (cons_dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", cons_dout); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_write();
        prod_start = 1;
        step();
        n_checks++; if (prod_grant !== 1'b1 || prod_bank !== 1'b0) begin n_fail++; $display("FAIL wr_grant got g=%0b b=%0b exp g=1 b=0", prod_grant, prod_bank); end
        prod_we = 1; prod_addr = 12'd5; prod_din = 64'hA5;
        #1;
        n_checks++; if (b0_we !== 1'b1 || b0_addr !== 12'd5 || b0_din !== 64'hA5 || b1_we !== 1'b0)
            begin n_fail++; $display("FAIL wr_bank0_port got we=%0b a=%0d d=%h we1=%0b exp 1/5/a5/0", b0_we, b0_addr, b0_din, b1_we); end
        step();
        prod_we = 0; prod_done = 1;
        step();
        prod_done = 0;
        n_checks++; if (prod_grant !== 1'b0 || prod_bank !== 1'b1) begin n_fail++; $display("FAIL wr_done got g=%0b b=%0b exp g=0 b=1", prod_grant, prod_bank); end
        step();
        n_checks++; if (prod_grant !== 1'b1 || prod_bank !== 1'b1) begin n_fail++; $display("FAIL wr_regrant got g=%0b b=%0b exp g=1 b=1", prod_grant, prod_bank); end
    endtask

    task automatic test_read();
        cons_start = 1;
        step();
        n_checks++; if (cons_grant !== 1'b1 || cons_bank !== 1'b0) begin n_fail++; $display("FAIL rd_grant got g=%0b b=%0b exp g=1 b=0", cons_grant, cons_bank); end
        cons_re = 1; cons_addr = 12'd5;
        prod_we = 1; prod_addr = 12'd7; prod_din = 64'h77;
        #1;
        n_checks++; if (b0_addr !== 12'd5 || b0_we !== 1'b0 || b1_we !== 1'b1 || b1_addr !== 12'd7)
            begin n_fail++; $display("FAIL rd_port_split got a0=%0d we0=%0b we1=%0b a1=%0d exp 5/0/1/7", b0_addr, b0_we, b1_we, b1_addr); end
        step();
        cons_re = 0; prod_we = 0;
        n_checks++; if (cons_dvalid !== 1'b1 || cons_dout !== 64'hA5) begin n_fail++; $display("FAIL rd_data got v=%0b d=%h exp v=1 d=a5", cons_dvalid, cons_dout); end
        step();
        n_checks++; if (cons_dvalid !== 1'b0 || cons_dout !== '0) begin n_fail++; $display("FAIL rd_idle got v=%0b d=%h exp v=0 d=0", cons_dvalid, cons_dout); end
    endtask

    task automatic test_throttle();
        prod_done = 1;
        step();
        prod_done = 0;
        n_checks++; if (prod_grant !== 1'b0 || prod_bank !== 1'b0) begin n_fail++; $display("FAIL thr_done got g=%0b b=%0b exp g=0 b=0", prod_grant, prod_bank); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (prod_grant !== 1'b0) begin n_fail++; $display("FAIL thr_stall_%0d got %0b exp 0", i, prod_grant); end
        end
        cons_done = 1;
        step();
        cons_done = 0;
        n_checks++; if (prod_grant !== 1'b1 || prod_bank !== 1'b0 || cons_grant !== 1'b0 || cons_bank !== 1'b1)
            begin n_fail++; $display("FAIL thr_release got pg=%0b pb=%0b cg=%0b cb=%0b exp 1/0/0/1", prod_grant, prod_bank, cons_grant, cons_bank); end
        prod_we = 1; prod_addr = 12'd9; prod_din = 64'h99;
        step();
        prod_we = 0;
        n_checks++; if (cons_grant !== 1'b1 || cons_bank !== 1'b1) begin n_fail++; $display("FAIL thr_cons_next got g=%0b b=%0b exp g=1 b=1", cons_grant, cons_bank); end
    endtask

    task automatic test_simultaneous();
        prod_done = 1; cons_done = 1;
        step();
        prod_done = 0; cons_done = 0;
        n_checks++; if ({prod_grant, prod_bank, cons_grant, cons_bank} !== 4'b0100)
            begin n_fail++; $display("FAIL sim_done got %b exp 0100", {prod_grant, prod_bank, cons_grant, cons_bank}); end
        step();
        n_checks++; if ({prod_grant, prod_bank, cons_grant, cons_bank, err} !== 5'b11100)
            begin n_fail++; $display("FAIL sim_regrant got %b exp 11100", {prod_grant, prod_bank, cons_grant, cons_bank, err}); end
        cons_re = 1; cons_addr = 12'd9;
        step();
        cons_re = 0;
        n_checks++; if (cons_dvalid !== 1'b1 || cons_dout !== 64'h99) begin n_fail++; $display("FAIL sim_frame_data got v=%0b d=%h exp v=1 d=99", cons_dvalid, cons_dout); end
        cons_start = 0; cons_done = 1;
        step();
        cons_done = 0;
`ifdef CONV_PINGPONG_STATS_EN
        n_checks++; if (frames_wr !== 16'd3 || frames_rd !== 16'd3) begin n_fail++; $display("FAIL stats_frames got wr=%0d rd=%0d exp 3/3", frames_wr, frames_rd); end
`endif
        prod_start = 0; prod_done = 1;
        step();
        prod_done = 0;
        n_checks++; if (prod_grant !== 1'b0 || cons_grant !== 1'b0 || err !== 1'b0)
            begin n_fail++; $display("FAIL sim_idle got pg=%0b cg=%0b err=%0b exp 0/0/0", prod_grant, cons_grant, err); end
    endtask

    task automatic test_misuse();
        prod_we = 1; prod_addr = 12'd3; prod_din = 64'h33;
        #1;
        n_checks++; if (b0_we !== 1'b0 || b1_we !== 1'b0) begin n_fail++; $display("FAIL mis_we_blocked got we0=%0b we1=%0b exp 0/0", b0_we, b1_we); end
        step();
        prod_we = 0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mis_err_set got %0b exp 1", err); end
        cons_re = 1;
        step();
        cons_re = 0;
        n_checks++; if (cons_dvalid !== 1'b0) begin n_fail++; $display("FAIL mis_re_blocked got %0b exp 0", cons_dvalid); end
        step(); step();
        n_checks++; if (err !== 1'b1 || prod_bank !== 1'b0 || cons_bank !== 1'b1)
            begin n_fail++; $display("FAIL mis_sticky got err=%0b pb=%0b cb=%0b exp 1/0/1", err, prod_bank, cons_bank); end
    endtask

    task automatic test_reset_mid_write();
        prod_start = 1;
        step();
        prod_we = 1; prod_addr = 12'd1; prod_din = 64'h11;
        #1;
        n_checks++; if (prod_grant !== 1'b1 || b0_we !== 1'b1) begin n_fail++; $display("FAIL mid_write_setup got g=%0b we0=%0b exp 1/1", prod_grant, b0_we); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({prod_grant, cons_grant, prod_bank, cons_bank, err, cons_dvalid, b0_we, b1_we} !== 8'h00)
            begin n_fail++; $display("FAIL mid_reset got %b exp 00000000", {prod_grant, cons_grant, prod_bank, cons_bank, err, cons_dvalid, b0_we, b1_we}); end
`ifdef CONV_PINGPONG_STATS_EN
        n_checks++; if (frames_wr !== 16'd0 || frames_rd !== 16'd0 || stall_cyc !== 32'd0)
            begin n_fail++; $display("FAIL mid_reset_stats got %0d/%0d/%0d exp 0/0/0", frames_wr, frames_rd, stall_cyc); end
`endif
        prod_we = 0; prod_start = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_throttle();
        test_simultaneous();
        test_misuse();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
